mult_lut_seq: RTL

//  Sequential unsigned WIDTH x WIDTH integer multiplier built on the combinational 6x6 mult_lut.

---
 rtl/mult_lut_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mult_lut_seq.sv
// mult_lut_seq -- sequential unsigned WIDTH x WIDTH multiplier.
//
// Each operand is split into N = WIDTH/6 six-bit digits. One digit pair per
// cycle is looked up in the combinational 6x6 mult_lut. The 12-bit partial
// product is registered and then shifted and accumulated into a 2*WIDTH-bit
// accumulator. Registering the partial product keeps the LUT and the wide
// adder in separate cycles. The cost is one drain cycle after the last
// lookup, so a result is ready N*N+1 edges after the accepting edge.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   operands valid        in_ready   idle, operands accepted
//   a_i, b_i   unsigned operands     product_o  a*b, registered, 2*WIDTH bits
//   out_valid  product valid         out_ready  consumer accepts product
//
// mult_lut -- combinational 6x6 unsigned multiply table.
//   addr[11:6] = multiplicand digit, addr[5:0] = multiplier digit.
//   data_o = 12-bit product.

module mult_lut (
    input  logic [11:0] addr,
    output logic [11:0] data_o
);
    assign data_o = {6'b0, addr[11:6]} * {6'b0, addr[5:0]};
endmodule

module mult_lut_seq #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int N    = WIDTH / 6;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int SHW  = CW + 1;       // holds i+j, up to 2N-2
    localparam int ACCW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state, state_nxt;
    logic [N-1:0][5:0]   a_dig, b_dig;
    logic [CW-1:0]       i_q, j_q;
    logic                drain_q;       // all digit pairs issued; one add left
    logic [11:0]         pp_q;
    logic [SHW-1:0]      sh_q;          // digit weight (i+j) of pp_q
    logic                pp_vld;
    logic [ACCW-1:0]     acc_q, product_q;

    logic [11:0]         lut_data;
    logic [ACCW-1:0]     pp_ext, term, acc_sum;
    logic [SHW+2:0]      shamt;

    mult_lut u_lut (
        .addr   ({a_dig[i_q], b_dig[j_q]}),
        .data_o (lut_data)
    );

    // Shift and add for the registered partial product. 6*sh is built as 4*sh + 2*sh.
    always_comb begin
        pp_ext       = '0;
        pp_ext[11:0] = pp_q;
        shamt        = {1'b0, sh_q, 2'b00} + {2'b00, sh_q, 1'b0};
        term         = pp_vld ? (pp_ext << shamt) : '0;
        acc_sum      = acc_q + term;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                if (drain_q) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_dig     <= '0;
            b_dig     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            drain_q   <= 1'b0;
            pp_q      <= '0;
            sh_q      <= '0;
            pp_vld    <= 1'b0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_dig   <= a_i;
                        b_dig   <= b_i;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        drain_q <= 1'b0;
                        pp_vld  <= 1'b0;
                    end
                end
                MUL: begin
                    acc_q <= acc_sum;
                    if (!drain_q) begin
                        pp_q   <= lut_data;
                        sh_q   <= {1'b0, i_q} + {1'b0, j_q};
                        pp_vld <= 1'b1;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) drain_q <= 1'b1;
                            else             i_q     <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        // Fold in the last partial product and publish the result.
                        product_q <= acc_sum;
                        pp_vld    <= 1'b0;
                        drain_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product_o = product_q;

endmodule
